// File: rtl/instr_realigner.sv
// instr_realigner: turns word-aligned fetch words into one RVC-aware instruction per handshake.
module instr_realigner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  input  logic [31:0] fetch_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_is_c
);
  typedef enum logic [1:0] {ALIGNED, HALF_START, RESIDUE} state_t;
  state_t      state_q, state_d;
  logic [31:0] cur_pc_q, cur_pc_d;
  logic [29:0] exp_word_q, exp_word_d;
  logic [15:0] residue_q, residue_d;
  logic        match, stale, lo_c, res_c, fire, take;
  logic [1:0]  unused_fetch_pc_lo;
  assign unused_fetch_pc_lo = fetch_pc[1:0];
  always_comb begin
    match       = fetch_valid && (fetch_pc[31:2] == exp_word_q);
    stale       = fetch_valid && !match;
    lo_c        = fetch_data[1:0] != 2'b11;
    res_c       = residue_q[1:0] != 2'b11;
    inst_valid  = 1'b0;
    fetch_ready = 1'b0;
    inst        = 32'h0;
    inst_is_c   = 1'b0;
    inst_pc     = cur_pc_q;
    if (!reset) begin
      if (flush) fetch_ready = 1'b1;
      else case (state_q)
        ALIGNED: begin
          inst_valid  = match;
          inst_is_c   = lo_c;
          inst        = lo_c ? {16'h0, fetch_data[15:0]} : fetch_data;
          fetch_ready = stale || (match && inst_ready);
        end
        HALF_START: fetch_ready = fetch_valid;
        default: begin
          inst_valid  = res_c || match;
          inst_is_c   = res_c;
          inst        = res_c ? {16'h0, residue_q} : {fetch_data[15:0], residue_q};
          fetch_ready = !res_c && (stale || (match && inst_ready));
        end
      endcase
    end
  end
  // A matching word is consumed exactly when fetch_ready is high for it; its upper half
  // always becomes the new residue, which is harmless in ALIGNED where it is never read.
  always_comb begin
    fire       = inst_valid && inst_ready;
    take       = match && fetch_ready;
    exp_word_d = take ? exp_word_q + 30'd1 : exp_word_q;
    residue_d  = take ? fetch_data[31:16] : residue_q;
    cur_pc_d   = fire ? cur_pc_q + (inst_is_c ? 32'd2 : 32'd4) : cur_pc_q;
    state_d    = state_q;
    case (state_q)
      ALIGNED:    state_d = (fire && lo_c) ? RESIDUE : ALIGNED;
      HALF_START: state_d = take ? RESIDUE : HALF_START;
      default:    state_d = (fire && res_c) ? ALIGNED : RESIDUE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RESET_PC[1] ? HALF_START : ALIGNED;
      cur_pc_q   <= RESET_PC & 32'hFFFF_FFFE;
      exp_word_q <= RESET_PC[31:2];
      residue_q  <= 16'h0;
    end else if (flush) begin
      state_q    <= redirect_pc[1] ? HALF_START : ALIGNED;
      cur_pc_q   <= redirect_pc & 32'hFFFF_FFFE;
      exp_word_q <= redirect_pc[31:2];
      residue_q  <= 16'h0;
    end else begin
      state_q    <= state_d;
      cur_pc_q   <= cur_pc_d;
      exp_word_q <= exp_word_d;
      residue_q  <= residue_d;
    end
  end
endmodule

// File: tb/tb_instr_realigner.sv
// tb_instr_realigner: directed vectors with hand-computed expectations for instr_realigner.
module tb_instr_realigner;
  logic        clk = 1'b0;
  logic        reset, flush, fetch_valid, fetch_ready, inst_valid, inst_ready, inst_is_c;
  logic [31:0] redirect_pc, fetch_data, fetch_pc, inst, inst_pc;
  int          total = 0;
  int          bad = 0;
  instr_realigner dut (
    .clk(clk), .reset(reset), .flush(flush), .redirect_pc(redirect_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_data(fetch_data),
    .fetch_pc(fetch_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_is_c(inst_is_c)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic fv, input logic [31:0] fd, input logic [31:0] fpc);
    fetch_valid = fv;
    fetch_data  = fd;
    fetch_pc    = fpc;
    #1;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic out(input string tag, input logic v, input logic [31:0] i, input logic [31:0] pc, input logic c, input logic fr);
    chk({tag, ".valid"}, inst_valid, v);
    if (v) begin
      chk({tag, ".inst"}, inst, i);
      chk({tag, ".pc"}, inst_pc, pc);
      chk({tag, ".c"}, inst_is_c, c);
    end
    chk({tag, ".fready"}, fetch_ready, fr);
  endtask
  task automatic redirect(input logic [31:0] pc);
    flush = 1'b1;
    redirect_pc = pc;
    drive(1'b0, 32'h0, 32'h0);
    out("flush", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick;
    flush = 1'b0;
  endtask
  initial begin
    reset = 1'b1; flush = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1;
    drive(1'b1, 32'h0000_0013, 32'h0);
    out("rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("rst.inst", inst, 32'h0);
    chk("rst.c", inst_is_c, 32'h0);
    tick;
    reset = 1'b0;
    drive(1'b1, 32'h0000_0013, 32'h0);
    out("r35a", 1'b1, 32'h0000_0013, 32'h0, 1'b0, 1'b1);
    tick;
    drive(1'b1, 32'h00B5_0533, 32'h4);
    out("r35b", 1'b1, 32'h00B5_0533, 32'h4, 1'b0, 1'b1);
    tick;
    redirect(32'h0);
    drive(1'b1, 32'h4501_4501, 32'h0);
    out("r36a", 1'b1, 32'h0000_4501, 32'h0, 1'b1, 1'b1);
    tick;
    drive(1'b1, 32'h0000_0013, 32'h4);
    out("r36b", 1'b1, 32'h0000_4501, 32'h2, 1'b1, 1'b0);
    tick;
    redirect(32'h0);
    drive(1'b1, 32'h0013_4501, 32'h0);
    out("r37a", 1'b1, 32'h0000_4501, 32'h0, 1'b1, 1'b1);
    tick;
    drive(1'b1, 32'h4501_0000, 32'h4);
    out("r37b", 1'b1, 32'h0000_0013, 32'h2, 1'b0, 1'b1);
    tick;
    drive(1'b0, 32'h0, 32'h0);
    out("r37c", 1'b1, 32'h0000_4501, 32'h6, 1'b1, 1'b0);
    tick;
    redirect(32'h102);
    drive(1'b1, 32'hDEAD_BEEF, 32'h8);
    out("r38stale", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick;
    drive(1'b1, 32'h0013_0000, 32'h100);
    out("r38half", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick;
    drive(1'b1, 32'h4501_0000, 32'h104);
    out("r38span", 1'b1, 32'h0000_0013, 32'h102, 1'b0, 1'b1);
    tick;
    drive(1'b0, 32'h0, 32'h0);
    out("r38tail", 1'b1, 32'h0000_4501, 32'h106, 1'b1, 1'b0);
    tick;
    redirect(32'h200);
    inst_ready = 1'b0;
    drive(1'b1, 32'h00B5_0533, 32'h200);
    for (int i = 0; i < 3; i++) begin
      out("r39hold", 1'b1, 32'h00B5_0533, 32'h200, 1'b0, 1'b0);
      tick;
    end
    inst_ready = 1'b1;
    #1;
    out("r39rel", 1'b1, 32'h00B5_0533, 32'h200, 1'b0, 1'b1);
    tick;
    drive(1'b1, 32'h0000_0013, 32'h204);
    out("r39next", 1'b1, 32'h0000_0013, 32'h204, 1'b0, 1'b1);
    tick;
    redirect(32'hFFFF_FFFC);
    drive(1'b1, 32'h00B5_0533, 32'hFFFF_FFFC);
    out("wrap_a", 1'b1, 32'h00B5_0533, 32'hFFFF_FFFC, 1'b0, 1'b1);
    tick;
    drive(1'b1, 32'h0000_0013, 32'h0);
    out("wrap_b", 1'b1, 32'h0000_0013, 32'h0, 1'b0, 1'b1);
    tick;
    redirect(32'h300);
    drive(1'b1, 32'h0013_4501, 32'h300);
    out("r40a", 1'b1, 32'h0000_4501, 32'h300, 1'b1, 1'b1);
    tick;
    drive(1'b0, 32'h0, 32'h0);
    out("r40wait", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    drive(1'b1, 32'h4501_0000, 32'h304);
    out("r40rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick;
    reset = 1'b0;
    drive(1'b1, 32'h4501_0000, 32'h304);
    out("r40stale", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick;
    drive(1'b1, 32'h00B5_0533, 32'h0);
    out("r40word0", 1'b1, 32'h00B5_0533, 32'h0, 1'b0, 1'b1);
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_realigner.md
INSTR_REALIGNER -- requirements
Module: instr_realigner

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC of the first instruction after reset (bit 0 ignored).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  redirect request; discards all held state.
REQ-005 SHALL have port redirect_pc  input  32  target PC, sampled when flush=1.
REQ-006 SHALL have port fetch_valid  input  1  fetch word present.
REQ-007 SHALL have port fetch_ready  output  1  fetch word consumed this cycle.
REQ-008 SHALL have port fetch_data  input  32  word-aligned instruction memory word, little-endian halfwords.
REQ-009 SHALL have port fetch_pc  input  32  word address of fetch_data, bits[1:0]=0.
REQ-010 SHALL have port inst_valid  output  1  aligned instruction present.
REQ-011 SHALL have port inst_ready  input  1  downstream accepts instruction.
REQ-012 SHALL have port inst  output  32  aligned instruction; upper 16 bits zero when compressed.
REQ-013 SHALL have port inst_pc  output  32  PC of inst.
REQ-014 SHALL have port inst_is_c  output  1  inst is a 16-bit compressed instruction.

Function
REQ-015 SHALL classify a halfword as compressed iff bits[1:0] != 2'b11.
REQ-016 SHALL hold registers: state, cur_pc, exp_word (next expected fetch word address, 30 bits), residue (16 bits).
REQ-017 SHALL implement states ALIGNED (instruction starts at lower half of next word), HALF_START (instruction starts at upper half of next word; lower half discarded), RESIDUE (residue holds the halfword at cur_pc).
REQ-018 SHALL treat a fetch word as stale when fetch_valid=1 and fetch_pc[31:2] != exp_word; stale words: fetch_ready=1, no output, no state change.
REQ-019 ALIGNED, matching word, lower half 32-bit: inst=fetch_data, inst_is_c=0; on handshake consume word, cur_pc+=4, stay ALIGNED.
REQ-020 ALIGNED, matching word, lower half compressed: inst={16'h0,fetch_data[15:0]}, inst_is_c=1; on handshake consume word, residue<=fetch_data[31:16], cur_pc+=2, go RESIDUE.
REQ-021 HALF_START, matching word: fetch_ready=1, inst_valid=0; consume word, residue<=fetch_data[31:16], go RESIDUE; cur_pc unchanged.
REQ-022 RESIDUE, residue compressed: inst={16'h0,residue}, inst_is_c=1, fetch_ready=0 independent of fetch_valid; on handshake cur_pc+=2, go ALIGNED.
REQ-023 RESIDUE, residue 32-bit: inst_valid only with matching fetch word; inst={fetch_data[15:0],residue}, inst_is_c=0; on handshake consume word, residue<=fetch_data[31:16], cur_pc+=4, stay RESIDUE.
REQ-024 SHALL increment exp_word by 1 on every consumed non-stale word, wrapping modulo 2^30.
REQ-025 SHALL assert fetch_ready for a matching word in ALIGNED/RESIDUE-32-bit only when inst_ready=1 (word consumed only with instruction handshake).
REQ-026 SHALL produce outputs combinationally from state, residue, fetch inputs (zero-cycle latency); inst_pc=cur_pc always.
REQ-027 SHALL keep inst, inst_pc, inst_is_c stable while inst_valid=1 and inst_ready=0, given stable fetch inputs.
REQ-028 cur_pc arithmetic SHALL be 32-bit, wrapping at 2^32; bit 0 always 0.
REQ-029 flush=1 SHALL win over all handshakes that cycle: inst_valid=0, fetch_ready=1 (incoming word dropped), cur_pc<=redirect_pc with bit0=0, exp_word<=redirect_pc[31:2], residue discarded, state<=HALF_START if redirect_pc[1] else ALIGNED.
REQ-030 SHALL never output an instruction formed from halfwords of different flush epochs.

Reset
REQ-031 reset=1 SHALL have priority over flush and all handshakes.
REQ-032 On reset: cur_pc=RESET_PC with bit0=0, exp_word=RESET_PC[31:2], residue=16'h0, state=HALF_START if RESET_PC[1] else ALIGNED.
REQ-033 During reset cycle inst_valid=0, fetch_ready=0; outputs inst=0, inst_is_c=0.
REQ-034 Reset asserted mid-instruction (RESIDUE holding 32-bit lower half) SHALL discard residue; no partial instruction emitted afterward.

Verification
REQ-035 Words 0x00000013@0x0, 0x00B50533@0x4, inst_ready=1 -> two 32-bit insts, pc 0x0, 0x4, inst_is_c=0, one per cycle.
REQ-036 Word 0x45014501@0x0 -> inst 0x4501 pc 0x0, then 0x4501 pc 0x2 with fetch_ready=0 in second cycle; both inst_is_c=1.
REQ-037 Words 0x00134501@0x0, 0x45010000@0x4 -> 0x4501@0x0 (c), 0x00000013@0x2 (32-bit spanning), then 0x4501@0x6 (c).
REQ-038 flush with redirect_pc=0x102, then stale word@0x8, then 0x00130000@0x100, 0x45010000@0x104 -> stale dropped, lower half discarded, inst 0x00000013@0x102.
REQ-039 inst_ready=0 for 3 cycles with 32-bit inst pending -> fetch_ready=0, outputs stable; releases with single transfer.
REQ-040 reset asserted in RESIDUE with pending 32-bit lower half, RESET_PC=0x0 -> next inst is fetch word@0x0 only.
